// File: rtl/digitizer_stream_pkg.sv
// Shared types and trailer layout for the acquisition-FIFO drain/framer path.
package digitizer_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } state_t;

  localparam int TRL_MAGIC_LSB = 24;
  localparam int TRL_SEQ_LSB   = 16;
  localparam int TRL_LEN_LSB   = 0;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // Trailer word layout: magic 31:24, sequence 23:16, payload length 15:0.
  function automatic logic [31:0] build_trailer(input logic [7:0]  magic,
                                                 input logic [7:0]  seq,
                                                 input logic [15:0] len);
    logic [31:0] w;
    w = '0;
    w[TRL_MAGIC_LSB +: 8] = magic;
    w[TRL_SEQ_LSB   +: 8] = seq;
    w[TRL_LEN_LSB   +: 16] = len;
    return w;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Read-latency tracker plus small skid FIFO that absorbs words already requested
// from the non-FWFT FIFO while the downstream stream is stalled.
module fifo_rd_skid #(
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic              credit,
  output logic              drained
);

  localparam int DEPTH = RD_LATENCY + 1;
  localparam int CW    = 3;

  logic [RD_LATENCY-1:0] pipe;
  logic [DATA_W-1:0]     mem [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         in_flight;
  logic                  capture;
  logic                  do_pop;

  assign capture    = pipe[RD_LATENCY-1];
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
  assign do_pop     = pop && head_valid;
  assign drained    = !head_valid && (in_flight == '0);

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + CW'(pipe[i]);
    end
  end

  // A slot freed by this cycle's pop may be reused, which keeps one word per cycle flowing.
  assign credit = (count + in_flight) < (CW'(DEPTH) + CW'(do_pop));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      pipe[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
      if (capture) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + CW'(capture) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= fifo_q;
    end
  end

endmodule

// File: rtl/fifo_drain_framer.sv
// Drains the acquisition FIFO and emits payload beats followed by one trailer beat
// (magic, sequence, length) per frame on a valid/ready stream.
module fifo_drain_framer
  import digitizer_stream_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter int         MAX_LEN     = 256,
  parameter int         RD_LATENCY  = 1,
  parameter logic [7:0] MAGIC       = DEFAULT_MAGIC,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              fifo_re,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_last,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  state_t            state;
  state_t            state_nx;
  logic [15:0]       issued;
  logic [15:0]       sent;
  logic [31:0]       idle_cnt;
  logic [7:0]        seq;
  logic [DATA_W-1:0] head_data;
  logic              head_valid;
  logic              credit;
  logic              drained;
  logic              load_en;
  logic              pop;
  logic              trailer_load;
  logic              trailer_xfer;
  logic              close_cond;

  fifo_rd_skid #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en      (fifo_re),
    .fifo_q     (fifo_q),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .credit     (credit),
    .drained    (drained)
  );

  assign load_en      = !o_valid || o_ready;
  assign pop          = load_en && head_valid;
  assign trailer_xfer = o_valid && o_ready && o_last;
  // Once the trailer sits in the output register it must not be reloaded.
  assign trailer_load = (state == TRAILER) && load_en && !(o_valid && o_last);
  assign busy         = (state != IDLE);

  assign fifo_re = reset_n && (state == PAYLOAD) && enable && !fifo_empty &&
                   credit && (issued < 16'(MAX_LEN));

  assign close_cond = (issued == 16'(MAX_LEN)) ||
                      ((TIMEOUT_CYC != 0) && (idle_cnt == 32'(TIMEOUT_CYC))) ||
                      !enable;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_nx = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // Only close when nothing is pending, so no requested word is ever orphaned.
        if (drained && !fifo_re) begin
          if ((sent != 16'd0) && close_cond) begin
            state_nx = TRAILER;
          end else if (!enable && (sent == 16'd0)) begin
            state_nx = IDLE;
          end
        end
      end
      TRAILER: begin
        if (trailer_xfer) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issued    <= '0;
      sent      <= '0;
      idle_cnt  <= '0;
      seq       <= '0;
      frame_cnt <= '0;
    end else begin
      if ((state == IDLE) && (state_nx == PAYLOAD)) begin
        issued   <= '0;
        sent     <= '0;
        idle_cnt <= '0;
      end else if (state == PAYLOAD) begin
        if (fifo_re) begin
          issued <= issued + 16'd1;
        end
        if (pop) begin
          sent     <= sent + 16'd1;
          idle_cnt <= '0;
        end else if (drained && !fifo_re && (idle_cnt < 32'(TIMEOUT_CYC))) begin
          idle_cnt <= idle_cnt + 32'd1;
        end
      end
      if (trailer_xfer) begin
        seq       <= seq + 8'd1;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (load_en) begin
      if (pop) begin
        o_valid <= 1'b1;
        o_data  <= head_data;
        o_last  <= 1'b0;
      end else if (trailer_load) begin
        o_valid <= 1'b1;
        o_data  <= DATA_W'(build_trailer(MAGIC, seq, sent));
        o_last  <= 1'b1;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
